// File: rtl/div_ratio_checker.sv
// rtl/div_ratio_checker.sv - measures high/low phase lengths of a divided clock and flags ratio errors
// Reports the last complete period, pulses err on a mismatch and tracks lock over consecutive good periods.
module div_ratio_checker #(
    parameter int EXP_HIGH = 40,
    parameter int EXP_LOW  = 40,
    parameter int TOL      = 0,
    parameter int LOCK_N   = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic             period_valid,
    output logic             err,
    output logic             locked,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]   EXP_H_V  = (CNT_W+1)'(EXP_HIGH);
    localparam logic [CNT_W:0]   EXP_L_V  = (CNT_W+1)'(EXP_LOW);
    localparam logic [CNT_W:0]   TOL_V    = (CNT_W+1)'(TOL);
    localparam logic [3:0]       LOCK_V   = 4'(LOCK_N);

    state_t           state_q, state_d;
    logic             d1_q, d1_d;
    logic             d2_q, d2_d;
    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] lc_q, lc_d;
    logic [3:0]       good_run_q, good_run_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic             period_valid_q, period_valid_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             rise;
    logic             fall;
    logic [CNT_W:0]   hc_x;
    logic [CNT_W:0]   lc_x;
    logic [CNT_W:0]   diff_h;
    logic [CNT_W:0]   diff_l;
    logic             match;

    assign rise = d1_q & ~d2_q;
    assign fall = ~d1_q & d2_q;

    // Absolute deviations are taken one bit wider so the subtraction never wraps.
    always_comb begin
        hc_x   = {1'b0, hc_q};
        lc_x   = {1'b0, lc_q};
        diff_h = (hc_x >= EXP_H_V) ? (hc_x - EXP_H_V) : (EXP_H_V - hc_x);
        diff_l = (lc_x >= EXP_L_V) ? (lc_x - EXP_L_V) : (EXP_L_V - lc_x);
        match  = (diff_h <= TOL_V) && (diff_l <= TOL_V) &&
                 (hc_q != CNT_MAX) && (lc_q != CNT_MAX);
    end

    always_comb begin
        state_d        = state_q;
        d1_d           = div_in;
        d2_d           = d1_q;
        hc_d           = hc_q;
        lc_d           = lc_q;
        good_run_d     = good_run_q;
        high_cnt_d     = high_cnt_q;
        low_cnt_d      = low_cnt_q;
        period_valid_d = 1'b0;
        err_d          = 1'b0;
        locked_d       = locked_q;
        err_cnt_d      = err_cnt_q;

        case (state_q)
            S_SYNC: begin
                if (rise) begin
                    hc_d    = CNT_ONE;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (fall) begin
                    lc_d    = CNT_ONE;
                    state_d = S_LOW;
                end else if (d1_q && (hc_q != CNT_MAX)) begin
                    hc_d = hc_q + CNT_ONE;
                end
            end
            S_LOW: begin
                if (rise) begin
                    high_cnt_d     = hc_q;
                    low_cnt_d      = lc_q;
                    period_valid_d = 1'b1;
                    hc_d           = CNT_ONE;
                    state_d        = S_HIGH;
                    if (match) begin
                        good_run_d = (good_run_q >= LOCK_V) ? LOCK_V : (good_run_q + 4'd1);
                        if (good_run_d == LOCK_V) begin
                            locked_d = 1'b1;
                        end
                    end else begin
                        err_d      = 1'b1;
                        good_run_d = 4'd0;
                        locked_d   = 1'b0;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                end else if (!d1_q && (lc_q != CNT_MAX)) begin
                    lc_d = lc_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_SYNC;
            d1_q           <= 1'b0;
            d2_q           <= 1'b0;
            hc_q           <= '0;
            lc_q           <= '0;
            good_run_q     <= 4'd0;
            high_cnt_q     <= '0;
            low_cnt_q      <= '0;
            period_valid_q <= 1'b0;
            err_q          <= 1'b0;
            locked_q       <= 1'b0;
            err_cnt_q      <= 8'd0;
        end else begin
            state_q        <= state_d;
            d1_q           <= d1_d;
            d2_q           <= d2_d;
            hc_q           <= hc_d;
            lc_q           <= lc_d;
            good_run_q     <= good_run_d;
            high_cnt_q     <= high_cnt_d;
            low_cnt_q      <= low_cnt_d;
            period_valid_q <= period_valid_d;
            err_q          <= err_d;
            locked_q       <= locked_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign high_cnt     = high_cnt_q;
    assign low_cnt      = low_cnt_q;
    assign period_valid = period_valid_q;
    assign err          = err_q;
    assign locked       = locked_q;
    assign err_cnt      = err_cnt_q;

endmodule
